// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and types for the Game of Life neighbourhood
// scanner.
//   NBRS_CNT / SLOT_CNT : neighbour count and read slots per request.
//   ST_*                : scanner FSM state codes.
//   slot_e              : read slot order, with the centre cell read last.
//   dir_e               : per-axis offset (-1, 0, +1) applied to a coordinate.
//   tag_t               : per-slot tag that travels alongside a read in flight.
//   slot_dx / slot_dy   : offset tables that map a slot to its x / y direction.
//   conway_next         : Conway rule applied to the centre cell and its count.
package gol_pkg;

  localparam int NBRS_CNT = 8;
  localparam int SLOT_CNT = NBRS_CNT + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [3:0] {
    SLOT_NW = 4'd0, SLOT_N  = 4'd1, SLOT_NE = 4'd2,
    SLOT_W  = 4'd3, SLOT_E  = 4'd4,
    SLOT_SW = 4'd5, SLOT_S  = 4'd6, SLOT_SE = 4'd7,
    SLOT_C  = 4'd8
  } slot_e;

  typedef enum logic [1:0] {
    DIR_M1 = 2'd0,
    DIR_Z  = 2'd1,
    DIR_P1 = 2'd2
  } dir_e;

  typedef struct packed {
    logic vld;     // a slot was presented in this cycle
    logic rd_en;   // the slot actually performed a read
    logic centre;  // the slot was the centre cell
  } tag_t;

  function automatic dir_e slot_dx(input logic [3:0] slot);
    case (slot)
      SLOT_NW, SLOT_W, SLOT_SW: return DIR_M1;
      SLOT_NE, SLOT_E, SLOT_SE: return DIR_P1;
      default:                  return DIR_Z;
    endcase
  endfunction

  function automatic dir_e slot_dy(input logic [3:0] slot);
    case (slot)
      SLOT_NW, SLOT_N, SLOT_NE: return DIR_M1;
      SLOT_SW, SLOT_S, SLOT_SE: return DIR_P1;
      default:                  return DIR_Z;
    endcase
  endfunction

  function automatic logic conway_next(input logic centre, input logic [3:0] cnt);
    return centre ? (cnt == 4'd2 || cnt == 4'd3) : (cnt == 4'd3);
  endfunction

endpackage

// File: rtl/gol_nbr_offset.sv
// gol_nbr_offset: applies a -1/0/+1 offset to one coordinate axis.
//   i_coord    : coordinate of the centre cell on this axis
//   i_dir      : offset direction (gol_pkg::dir_e encoding)
//   o_adr      : resulting coordinate; wrapped when WRAP=1, don't-care when
//                the cell is not relevant
//   o_relevant : 0 when the offset falls outside the field and WRAP=0
module gol_nbr_offset
  import gol_pkg::*;
#(
  parameter int SIZE  = 30,
  parameter int WRAP  = 0,
  parameter int ADR_W = 5
) (
  input  logic [ADR_W-1:0] i_coord,
  input  logic [1:0]       i_dir,
  output logic [ADR_W-1:0] o_adr,
  output logic             o_relevant
);

  localparam logic [ADR_W-1:0] LAST = ADR_W'(SIZE - 1);

  always_comb begin
    o_adr      = i_coord;
    o_relevant = 1'b1;
    case (i_dir)
      DIR_M1: begin
        if (i_coord == '0) begin
          if (WRAP != 0) o_adr = LAST;
          else           o_relevant = 1'b0;
        end else begin
          o_adr = i_coord - ADR_W'(1);
        end
      end
      DIR_P1: begin
        if (i_coord == LAST) begin
          if (WRAP != 0) o_adr = '0;
          else           o_relevant = 1'b0;
        end else begin
          o_adr = i_coord + ADR_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gol_nbr_scanner.sv
// gol_nbr_scanner: sequential neighbourhood evaluator for the Game of Life.
// For each accepted request (x,y) it presents nine read slots, one per cycle
// (eight neighbours, then the centre), counts live neighbours as the data
// returns, and reports the Conway next state of the centre.
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i_start / o_ready             : request handshake (ready only in IDLE)
//   i_cell_x_adr / i_cell_y_adr   : centre coordinates, sampled on accept
//   o_rd_en / o_rd_x_adr / o_rd_y_adr / i_rd_data : field read port;
//                                   data returns RD_LATENCY cycles after o_rd_en
//   o_done                        : one-cycle result strobe
//   o_alive_cnt / o_next_alive / o_err : registered result, held until the
//                                   next accept
module gol_nbr_scanner
  import gol_pkg::*;
#(
  parameter  int FIELD_W    = 30,
  parameter  int FIELD_H    = 50,
  parameter  int WRAP       = 0,
  parameter  int RD_LATENCY = 1,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_ready,
  input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
  output logic                  o_rd_en,
  output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
  input  logic                  i_rd_data,
  output logic                  o_done,
  output logic [3:0]            o_alive_cnt,
  output logic                  o_next_alive,
  output logic                  o_err
);

  // One extra bit so that a power-of-two field size stays representable.
  localparam logic [X_ADR_SIZE:0] X_LIMIT = (X_ADR_SIZE + 1)'(FIELD_W);
  localparam logic [Y_ADR_SIZE:0] Y_LIMIT = (Y_ADR_SIZE + 1)'(FIELD_H);

  logic [1:0]            state_q, state_d;
  logic [3:0]            slot_q, slot_d;
  logic [X_ADR_SIZE-1:0] cx_q, cx_d;
  logic [Y_ADR_SIZE-1:0] cy_q, cy_d;
  logic                  rd_en_q, rd_en_d;
  logic [X_ADR_SIZE-1:0] rd_x_q, rd_x_d;
  logic [Y_ADR_SIZE-1:0] rd_y_q, rd_y_d;
  tag_t                  tag_q [RD_LATENCY];
  tag_t                  tag_d [RD_LATENCY];
  logic [3:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [3:0]            alive_q, alive_d;
  logic                  next_q, next_d;
  logic                  err_q, err_d;

  // The read registers are loaded one cycle ahead of the slot they show, so
  // the offset units look at the request inputs in IDLE and at the following
  // slot otherwise.
  logic                  idle;
  logic [X_ADR_SIZE-1:0] off_cx;
  logic [Y_ADR_SIZE-1:0] off_cy;
  logic [3:0]            off_slot;
  logic [1:0]            off_dx, off_dy;
  logic [X_ADR_SIZE-1:0] nx_adr;
  logic [Y_ADR_SIZE-1:0] ny_adr;
  logic                  nx_rel, ny_rel;
  logic                  out_of_range;
  tag_t                  last_tag;
  logic                  data_bit;

  assign idle     = (state_q == ST_IDLE);
  assign off_cx   = idle ? i_cell_x_adr : cx_q;
  assign off_cy   = idle ? i_cell_y_adr : cy_q;
  assign off_slot = idle ? 4'd0 : slot_q + 4'd1;
  assign off_dx   = slot_dx(off_slot);
  assign off_dy   = slot_dy(off_slot);

  gol_nbr_offset #(.SIZE(FIELD_W), .WRAP(WRAP), .ADR_W(X_ADR_SIZE)) u_off_x (
    .i_coord    (off_cx),
    .i_dir      (off_dx),
    .o_adr      (nx_adr),
    .o_relevant (nx_rel)
  );

  gol_nbr_offset #(.SIZE(FIELD_H), .WRAP(WRAP), .ADR_W(Y_ADR_SIZE)) u_off_y (
    .i_coord    (off_cy),
    .i_dir      (off_dy),
    .o_adr      (ny_adr),
    .o_relevant (ny_rel)
  );

  assign out_of_range = ({1'b0, i_cell_x_adr} >= X_LIMIT) ||
                        ({1'b0, i_cell_y_adr} >= Y_LIMIT);

  // The oldest tag lines up with i_rd_data; unread slots contribute nothing.
  assign last_tag = tag_q[RD_LATENCY-1];
  assign data_bit = last_tag.vld & last_tag.rd_en & i_rd_data;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    rd_en_d = 1'b0;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    alive_d = alive_q;
    next_d  = next_q;
    err_d   = err_q;

    tag_d[0].vld    = (state_q == ST_ISSUE);
    tag_d[0].rd_en  = rd_en_q;
    tag_d[0].centre = (slot_q == SLOT_C);
    for (int i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];

    if (data_bit && !last_tag.centre) cnt_d = cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          alive_d = 4'd0;
          next_d  = 1'b0;
          cnt_d   = 4'd0;
          if (out_of_range) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            err_d   = 1'b0;
            slot_d  = 4'd0;
            cx_d    = i_cell_x_adr;
            cy_d    = i_cell_y_adr;
            rd_en_d = nx_rel & ny_rel;
            rd_x_d  = nx_adr;
            rd_y_d  = ny_adr;
          end
        end
      end
      ST_ISSUE: begin
        if (slot_q == SLOT_C) begin
          state_d = ST_DRAIN;
        end else begin
          slot_d  = slot_q + 4'd1;
          rd_en_d = nx_rel & ny_rel;
          rd_x_d  = nx_adr;
          rd_y_d  = ny_adr;
        end
      end
      ST_DRAIN: begin
        // The centre is the final slot, so its return closes the count.
        if (last_tag.vld && last_tag.centre) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          alive_d = cnt_q;
          next_d  = conway_next(data_bit, cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= 4'd0;
      cx_q    <= '0;
      cy_q    <= '0;
      rd_en_q <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      alive_q <= 4'd0;
      next_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      rd_en_q <= rd_en_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= tag_d[i];
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      alive_q <= alive_d;
      next_q  <= next_d;
      err_q   <= err_d;
    end
  end

  assign o_ready      = idle;
  assign o_rd_en      = rd_en_q;
  assign o_rd_x_adr   = rd_x_q;
  assign o_rd_y_adr   = rd_y_q;
  assign o_done       = done_q;
  assign o_alive_cnt  = alive_q;
  assign o_next_alive = next_q;
  assign o_err        = err_q;

endmodule
